mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: slave-ack wait limit in cycles, 1..65535.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 m0_req  in  1  requester 0 (cpu data port) transaction request, level.
REQ-007 m0_we  in  1  requester 0 write enable (1 write, 0 read).
REQ-008 m0_addr  in  AW  requester 0 address.
REQ-009 m0_wdata  in  DW  requester 0 write data.
REQ-010 m0_rdata  out  DW  requester 0 read data, valid with m0_ack.
REQ-011 m0_ack  out  1  requester 0 completion, one-cycle pulse.
REQ-012 m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same widths and meaning for requester 1 (uart bootloader/programmer).
REQ-013 s_req  out  1  shared memory port request, held until s_ack or timeout.
REQ-014 s_we  out  1 / s_addr  out  AW / s_wdata  out  DW: latched fields of the granted requester.
REQ-015 s_rdata  in  DW / s_ack  in  1: slave read data and one-cycle completion.
REQ-016 grant  out  1  index of requester owning the current or last transaction.
REQ-017 timeout_err  out  1  sticky flag, set on any slave timeout.

Function
REQ-018 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-019 IDLE: no req asserted -> stay IDLE, s_req=0.
REQ-020 IDLE: any req asserted in cycle N -> arbitrate, latch winner's we/addr/wdata, set grant, enter BUSY; s_req=1 from cycle N+1.
REQ-021 BUSY: s_req=1 with latched fields stable; wait counter increments each cycle.
REQ-022 BUSY: s_ack=1 in cycle M -> register s_rdata, enter RESP; s_req=0 from cycle M+1.
REQ-023 RESP (cycle M+1): granted requester's ack=1 for exactly one cycle with registered rdata; other ack=0; next state IDLE.
REQ-024 Minimum request-to-ack latency 3 cycles (s_ack on first BUSY cycle); one IDLE cycle always separates transactions.
REQ-025 Timeout: counter reaches TIMEOUT in BUSY without s_ack -> rdata=0, enter RESP, set timeout_err; s_ack arriving after that point ignored.
REQ-026 Counter cleared on every entry to BUSY; 16 bits wide; saturation never reached since TIMEOUT<=65535.
REQ-027 Requester deasserting req during BUSY/RESP does not abort; transaction completes and ack still pulses.
REQ-028 Requester must hold req through its ack; req still high in the IDLE cycle after ack is a new transaction.
REQ-029 mX_rdata holds its last value between acks; write transactions return s_rdata as sampled (don't-care to requester).
REQ-030 s_we, s_addr, s_wdata hold the latched values outside BUSY; only s_req qualifies them.

Reset
REQ-031 rst=1 forces, asynchronously: state IDLE, s_req=0, m0_ack=0, m1_ack=0, grant=0, timeout_err=0, counter=0, m0_rdata=m1_rdata=0, s_we=0, s_addr=0, s_wdata=0, round-robin pointer=1 (requester 0 favoured first).
REQ-032 rst asserted mid-transaction abandons it; no ack is issued after rst release for the abandoned transaction.
REQ-033 timeout_err clears only on rst.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, requester other than the last granted wins; pointer updates on each grant.
REQ-035 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins simultaneous requests; no pointer register.
REQ-036 Single-requester behaviour is identical in both builds.

Verification
REQ-037 m0 read addr 0x00000010, slave returns 0xDEADBEEF with s_ack 1st BUSY cycle -> s_addr=0x10, s_we=0, m0_ack pulse 3 cycles after req, m0_rdata=0xDEADBEEF, m1_ack=0.
REQ-038 m0 and m1 requesting same cycle, both held for 2 transactions -> round-robin: grants 0 then 1; fixed: grants 0 then 0 while m0 held.
REQ-039 m1 write addr 0x100 data 0x12345678, slave never acks, TIMEOUT=4 -> s_req high 4 cycles, m1_ack pulse, m1_rdata=0, timeout_err=1 until rst.
REQ-040 rst pulsed while BUSY -> s_req=0 immediately, no m0_ack/m1_ack after release, next request served normally.
REQ-041 m0 drops req one cycle into BUSY, slave acks 5 cycles later -> m0_ack still pulses once, s_addr stable for all 5 cycles.
REQ-042 Back-to-back m0 reads held high -> exactly one IDLE cycle between s_req deassert and reassert, one ack per transaction.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle for mem_port_arbiter: two requester ports, the shared memory port and status.
// The arbiter uses the master modport; requesters and memory model sit on the slave modport.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;

  logic          s_req;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ack;

  logic          grant;
  logic          timeout_err;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output s_req, s_we, s_addr, s_wdata,
    input  s_rdata, s_ack,
    output grant, timeout_err
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  s_req, s_we, s_addr, s_wdata,
    output s_rdata, s_ack,
    input  grant, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter onto one shared memory port, with slave-ack timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed m0 priority.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  // Last BUSY cycle index before giving up; counter is 0 in the first BUSY cycle.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          grant_q, grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          timeout_err_q, timeout_err_d;
  logic [DW-1:0] rsp_data;
  logic          win;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q, rr_last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  always_comb begin
    win = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~rr_last_q;
`else
      win = 1'b0;
`endif
    end else if (bus.m1_req) begin
      win = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    timeout_err_d = timeout_err_q;
    rsp_data      = '0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d     = rr_last_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d = StBusy;
          cnt_d   = '0;
          grant_d = win;
          we_d    = win ? bus.m1_we    : bus.m0_we;
          addr_d  = win ? bus.m1_addr  : bus.m0_addr;
          wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d = win;
`endif
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 16'd1;
        // A slave ack in the final allowed cycle still wins over the timeout.
        if (bus.s_ack || (cnt_q == CntLast)) begin
          state_d  = StResp;
          rsp_data = bus.s_ack ? bus.s_rdata : '0;
          if (!bus.s_ack) begin
            timeout_err_d = 1'b1;
          end
          if (grant_q) begin
            m1_rdata_d = rsp_data;
          end else begin
            m0_rdata_d = rsp_data;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      grant_q       <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them immediately.
  assign bus.s_req       = (state_q == StBusy);
  assign bus.s_we        = we_q;
  assign bus.s_addr      = addr_q;
  assign bus.s_wdata     = wdata_q;
  assign bus.m0_ack      = (state_q == StResp) && !grant_q;
  assign bus.m1_ack      = (state_q == StResp) && grant_q;
  assign bus.m0_rdata    = m0_rdata_q;
  assign bus.m1_rdata    = m1_rdata_q;
  assign bus.grant       = grant_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
